// File: rtl/mem_bus_arbiter_pkg.sv
// Shared encodings for the instruction/data memory bus arbiter.
// Holds FSM state codes, bus owner codes and the byte-enable width.
package mem_bus_arbiter_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_BUS  = 2'd1,
      ARB_DONE = 2'd2
   } arbState_t;

   typedef enum logic {
      OWN_INST = 1'b0,
      OWN_DATA = 1'b1
   } arbOwner_t;

   localparam int unsigned BE_W = 4;
   localparam logic [BE_W-1:0] BE_NONE = '0;

   function automatic int unsigned timeoutCntWidth(input int unsigned limit);
      return $clog2(limit + 1);
   endfunction

endpackage

// File: rtl/mem_bus_arbiter_timeout_cnt.sv
// Bus-phase cycle counter: cleared on load, counts while inc, expire flags the last allowed cycle.
// Expire is combinational from the count; no handshake, the arbiter decides what to do with it.
module mem_bus_arbiter_timeout_cnt
   import mem_bus_arbiter_pkg::*;
#(
   parameter int unsigned LIMIT = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic inc,
   output logic expire
);

   localparam int unsigned CW = timeoutCntWidth(LIMIT);
   localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

   logic [CW-1:0] count;

   // Saturates at LAST so a stuck inc can never wrap back into a fresh budget.
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= '0;
      end else if (inc && (count != LAST)) begin
         count <= count + CW'(1);
      end
   end

   assign expire = inc && (count == LAST);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory bus between fetch and data ports, data first; 3 cycles minimum per access.
// Requesters are held off by stall_req until their 1-cycle ready pulse; the bus holds mem_req until mem_ack.
module mem_bus_arbiter
   import mem_bus_arbiter_pkg::*;
#(
   parameter int unsigned AW          = 32,
   parameter int unsigned DW          = 32,
   parameter int unsigned TIMEOUT_CYC = 255
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            inst_req,
   input  logic [AW-1:0]   inst_addr,
   output logic [DW-1:0]   inst_rdata,
   output logic            inst_ready,
   input  logic            data_req,
   input  logic [BE_W-1:0] data_we,
   input  logic [AW-1:0]   data_addr,
   input  logic [DW-1:0]   data_wdata,
   output logic [DW-1:0]   data_rdata,
   output logic            data_ready,
   output logic            mem_req,
   output logic [BE_W-1:0] mem_we,
   output logic [AW-1:0]   mem_addr,
   output logic [DW-1:0]   mem_wdata,
   input  logic [DW-1:0]   mem_rdata,
   input  logic            mem_ack,
   output logic            stall_req,
   output logic            bus_err
);

   arbState_t       state;
   arbState_t       nextState;
   arbOwner_t       owner;
   logic [AW-1:0]   addrQ;
   logic [BE_W-1:0] weQ;
   logic [DW-1:0]   wdataQ;
   logic [DW-1:0]   instRdataQ;
   logic [DW-1:0]   dataRdataQ;
   logic            busErrQ;

   logic            grant;
   logic            grantData;
   logic            ackSeen;
   logic            timeoutHit;
   logic            inBus;
   logic            expire;

   assign inBus = (state == ARB_BUS);

   mem_bus_arbiter_timeout_cnt #(
      .LIMIT (TIMEOUT_CYC)
   ) uTimeout (
      .clk    (clk),
      .rst    (rst),
      .load   (grant),
      .inc    (inBus),
      .expire (expire)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ARB_IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Data wins ties: the M-stage access is older than the fetch behind it.
   always_comb begin
      nextState  = state;
      grant      = 1'b0;
      grantData  = 1'b0;
      ackSeen    = 1'b0;
      timeoutHit = 1'b0;
      case (state)
         ARB_IDLE: begin
            if (data_req) begin
               grant     = 1'b1;
               grantData = 1'b1;
               nextState = ARB_BUS;
            end else if (inst_req) begin
               grant     = 1'b1;
               nextState = ARB_BUS;
            end
         end
         ARB_BUS: begin
            if (mem_ack) begin
               ackSeen   = 1'b1;
               nextState = ARB_DONE;
            end else if (expire) begin
               timeoutHit = 1'b1;
               nextState  = ARB_DONE;
            end
         end
         ARB_DONE: begin
            nextState = ARB_IDLE;
         end
         default: begin
            nextState = ARB_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         owner      <= OWN_INST;
         addrQ      <= '0;
         weQ        <= BE_NONE;
         wdataQ     <= '0;
         instRdataQ <= '0;
         dataRdataQ <= '0;
         busErrQ    <= 1'b0;
      end else begin
         if (grant) begin
            owner  <= grantData ? OWN_DATA : OWN_INST;
            addrQ  <= grantData ? data_addr : inst_addr;
            weQ    <= grantData ? data_we : BE_NONE;
            wdataQ <= grantData ? data_wdata : '0;
         end
         // Only the owner's read register moves; a timed-out access returns zero.
         if (ackSeen) begin
            if (owner == OWN_DATA) begin
               dataRdataQ <= mem_rdata;
            end else begin
               instRdataQ <= mem_rdata;
            end
         end else if (timeoutHit) begin
            busErrQ <= 1'b1;
            if (owner == OWN_DATA) begin
               dataRdataQ <= '0;
            end else begin
               instRdataQ <= '0;
            end
         end
      end
   end

   assign mem_req    = inBus;
   assign mem_we     = weQ;
   assign mem_addr   = addrQ;
   assign mem_wdata  = wdataQ;

   assign inst_ready = (state == ARB_DONE) && (owner == OWN_INST);
   assign data_ready = (state == ARB_DONE) && (owner == OWN_DATA);
   assign inst_rdata = instRdataQ;
   assign data_rdata = dataRdataQ;
   assign bus_err    = busErrQ;

   assign stall_req  = (inst_req & ~inst_ready) | (data_req & ~data_ready);

endmodule
